// File: rtl/conv_acmlt_pkg.sv
// Shared constants and encodings for the convolution accumulate datapath.
package conv_acmlt_pkg;
  localparam logic [31:0] INT32_MAX = 32'h7fff_ffff;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    CALFMT_INT8  = 2'b00,
    CALFMT_INT16 = 2'b01,
    CALFMT_FP16  = 2'b10
  } calfmt_e;
endpackage

// File: rtl/conv_mid_res_acmlt_lane.sv
// One accumulate lane: stage-1 lossless add, stage-2 overflow detect,
// clamp/wrap to int32 and ReLU.
module conv_mid_res_acmlt_lane
  import conv_acmlt_pkg::*;
#(
  parameter int IN_W = 37
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld1,
  input  logic            ld2,
  input  logic [IN_W-1:0] frac,
  input  logic [31:0]     org,
  input  logic            first,
  input  logic            sat_en,
  input  logic            relu_last,
  output logic [31:0]     data,
  output logic            ovf
);
  logic [IN_W:0] sum_d, sum_q;
  logic [31:0]   clip;

  always_comb begin
    sum_d = {frac[IN_W-1], frac} + (first ? '0 : {{(IN_W-31){org[31]}}, org});
  end

  // In int32 range iff bits [IN_W:31] are all equal.
  assign ovf = (|sum_q[IN_W:31]) & ~(&sum_q[IN_W:31]);

  always_comb begin
    clip = sum_q[31:0];
    if (ovf && sat_en) clip = sum_q[IN_W] ? INT32_MIN : INT32_MAX;
    if (relu_last && clip[31]) clip = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      data  <= '0;
    end else begin
      if (ld1) sum_q <= sum_d;
      if (ld2) data  <= clip;
    end
  end
endmodule

// File: rtl/conv_mid_res_acmlt_mc.sv
// Middle-result accumulator: LANE_N lanes behind a two-stage elastic pipeline
// with saturation event counter.
module conv_mid_res_acmlt_mc
  import conv_acmlt_pkg::*;
#(
  parameter int LANE_N    = 4,
  parameter int IN_W      = 37,
  parameter int SIM_DELAY = 1
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   aclken,
  input  logic                   sat_en,
  input  logic                   relu_en,
  input  logic                   sat_cnt_clr,
  input  logic [LANE_N*IN_W-1:0] s_frac,
  input  logic [LANE_N*32-1:0]   s_org_mid_res,
  input  logic                   s_first,
  input  logic                   s_last,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [LANE_N*32-1:0]   m_data,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [15:0]            sat_cnt
);
  logic                   v1, v2, last1, ovf2;
  logic                   ld1, ld2;
  logic [LANE_N-1:0]      lane_ovf;
  logic [LANE_N-1:0][31:0] lane_data;

  assign ld2     = aclken & (~v2 | m_ready);
  assign ld1     = aclken & (~v1 | ~v2 | m_ready);
  assign s_ready = ~areset & ld1;
  assign m_valid = v2;
  assign m_data  = lane_data;

  always_ff @(posedge aclk) begin
    if (areset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      last1   <= 1'b0;
      m_last  <= 1'b0;
      ovf2    <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (ld1) begin
        v1    <= s_valid;
        last1 <= s_last;
      end
      if (ld2) begin
        v2     <= v1;
        m_last <= last1;
        ovf2   <= |lane_ovf;
      end
      // Clear takes priority over a same-cycle increment.
      if (aclken && sat_cnt_clr)
        sat_cnt <= '0;
      else if (aclken && v2 && m_ready && ovf2 && !(&sat_cnt))
        sat_cnt <= sat_cnt + 16'd1;
    end
  end

  // Register delay is not modelled in synthesizable form; SIM_DELAY only gates elaboration.
  if (SIM_DELAY >= 0) begin : g_lanes
    for (genvar i = 0; i < LANE_N; i++) begin : g_lane
      conv_mid_res_acmlt_lane #(.IN_W(IN_W)) u_lane (
        .clk      (aclk),
        .rst      (areset),
        .ld1      (ld1),
        .ld2      (ld2),
        .frac     (s_frac[i*IN_W +: IN_W]),
        .org      (s_org_mid_res[i*32 +: 32]),
        .first    (s_first),
        .sat_en   (sat_en),
        .relu_last(relu_en & last1),
        .data     (lane_data[i]),
        .ovf      (lane_ovf[i])
      );
    end
  end
endmodule

// File: tb/tb_conv_mid_res_acmlt_mc.sv
// Randomized and directed bench for conv_mid_res_acmlt_mc against a queue-based model.
module tb_conv_mid_res_acmlt_mc;
  localparam int LANE_N = 4;
  localparam int IN_W   = 37;

  logic aclk = 1'b0;
  logic areset, aclken, sat_en, relu_en, sat_cnt_clr;
  logic [LANE_N*IN_W-1:0] s_frac;
  logic [LANE_N*32-1:0]   s_org_mid_res, m_data;
  logic s_first, s_last, s_valid, s_ready, m_last, m_valid, m_ready;
  logic [15:0] sat_cnt;

  conv_mid_res_acmlt_mc #(.LANE_N(LANE_N), .IN_W(IN_W), .SIM_DELAY(1)) dut (
    .aclk(aclk), .areset(areset), .aclken(aclken), .sat_en(sat_en), .relu_en(relu_en),
    .sat_cnt_clr(sat_cnt_clr), .s_frac(s_frac), .s_org_mid_res(s_org_mid_res),
    .s_first(s_first), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .sat_cnt(sat_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [LANE_N*32-1:0] d;
    logic                 l;
    bit                   ov;
  } beat_t;

  beat_t q[$];
  int    exp_sat = 0;
  int    n_tests = 0;
  int    n_fail  = 0;

  // Expected result of the beat currently on the input bus, straight from the arithmetic rules.
  function automatic beat_t model_beat();
    beat_t b;
    longint f, o, s;
    logic [31:0] w;
    b.ov = 1'b0;
    for (int i = 0; i < LANE_N; i++) begin
      f = $signed(s_frac[i*IN_W +: IN_W]);
      o = $signed(s_org_mid_res[i*32 +: 32]);
      s = s_first ? f : f + o;
      w = s[31:0];
      if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
        b.ov = 1'b1;
        if (sat_en) w = (s > 0) ? 32'h7fff_ffff : 32'h8000_0000;
      end
      if (relu_en && s_last && w[31]) w = '0;
      b.d[i*32 +: 32] = w;
    end
    b.l = s_last;
    return b;
  endfunction

  // One clock: observe handshakes just before the edge, update the model, return at next negedge.
  task automatic tick(output bit inf, output bit ofire, output beat_t act, output beat_t exp);
    #1;
    inf = 1'b0; ofire = 1'b0;
    act.d = m_data; act.l = m_last; act.ov = 1'b0;
    exp.d = '0; exp.l = 1'b0; exp.ov = 1'b0;
    if (areset) begin
      q.delete();
      exp_sat = 0;
    end else if (aclken) begin
      ofire = m_valid & m_ready;
      if (ofire) begin
        if (q.size() > 0) exp = q.pop_front();
        else begin exp.d = 'x; exp.l = 1'bx; end
      end
      if (sat_cnt_clr) exp_sat = 0;
      else if (ofire && exp.ov && exp_sat < 65535) exp_sat++;
      inf = s_valid & s_ready;
      if (inf) q.push_back(model_beat());
    end
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic set_idle();
    areset = 1'b0; aclken = 1'b1; sat_cnt_clr = 1'b0;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; m_ready = 1'b1;
  endtask

  task automatic rand_beat();
    longint v;
    for (int i = 0; i < LANE_N; i++) begin
      case ($urandom_range(0, 2))
        0:       v = {$urandom, $urandom};
        1:       v = longint'($signed($urandom));
        default: v = longint'($urandom_range(0, 2000)) - 1000;
      endcase
      s_frac[i*IN_W +: IN_W]    = v[IN_W-1:0];
      s_org_mid_res[i*32 +: 32] = $urandom;
    end
    s_first = ($urandom_range(0, 3) == 0);
    s_last  = 1'($urandom_range(0, 1));
  endtask

  // Lane 0 carries the given operands, other lanes zero; leaves the beat at the output.
  task automatic send_one(input longint f0, input longint o0, input bit first, input bit last);
    bit inf, o; beat_t a, e;
    s_frac = '0; s_org_mid_res = '0;
    s_frac[IN_W-1:0]    = f0[IN_W-1:0];
    s_org_mid_res[31:0] = o0[31:0];
    s_first = first; s_last = last; s_valid = 1'b1;
    tick(inf, o, a, e);
    s_valid = 1'b0;
    tick(inf, o, a, e);
  endtask

  task automatic test_reset();
    bit inf, o; beat_t a, e;
    set_idle(); sat_en = 1'b1; relu_en = 1'b0;
    s_frac = '0; s_org_mid_res = '0;
    areset = 1'b1; s_valid = 1'b1;
    #1;
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b exp 0", s_ready); end
    tick(inf, o, a, e);
    tick(inf, o, a, e);
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b exp 0", m_valid); end
    n_tests++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h exp 0", m_data); end
    n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b exp 0", m_last); end
    n_tests++; if (sat_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_sat_cnt: got %0d exp 0", sat_cnt); end
    areset = 1'b0; s_valid = 1'b0;
    #1;
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_s_ready: got %b exp 1", s_ready); end
  endtask

  task automatic test_basic();
    bit inf, o; beat_t a, e;
    set_idle(); sat_en = 1'b1; relu_en = 1'b0;
    s_frac = '0; s_org_mid_res = '0;
    s_frac[IN_W-1:0] = 37'd252; s_org_mid_res[31:0] = 32'd100; s_first = 1'b1; s_valid = 1'b1;
    tick(inf, o, a, e);
    n_tests++; if (inf !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b exp 1", inf); end
    s_valid = 1'b0;
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: m_valid %b exp 0", m_valid); end
    tick(inf, o, a, e);
    n_tests++; if (m_valid !== 1'b1 || m_data[31:0] !== 32'd252)
      begin n_fail++; $display("FAIL basic_lane0: valid %b data %0d exp 1/252", m_valid, m_data[31:0]); end
    s_frac = '0; s_org_mid_res = '0;
    s_frac[2*IN_W-1:IN_W] = 37'd7; s_org_mid_res[63:32] = 32'd8; s_first = 1'b0; s_valid = 1'b1;
    tick(inf, o, a, e);
    if (o) begin n_tests++; if (a.d !== e.d || a.l !== e.l) begin n_fail++; $display("FAIL basic_out: got %h/%b exp %h/%b", a.d, a.l, e.d, e.l); end end
    s_valid = 1'b0;
    tick(inf, o, a, e);
    n_tests++; if (m_valid !== 1'b1 || m_data[63:32] !== 32'd15)
      begin n_fail++; $display("FAIL basic_lane1: valid %b data %0d exp 1/15", m_valid, m_data[63:32]); end
    tick(inf, o, a, e);
    if (o) begin n_tests++; if (a.d !== e.d || a.l !== e.l) begin n_fail++; $display("FAIL basic_out: got %h/%b exp %h/%b", a.d, a.l, e.d, e.l); end end
  endtask

  task automatic test_sat();
    bit inf, o; beat_t a, e;
    set_idle(); sat_en = 1'b1; relu_en = 1'b0;
    sat_cnt_clr = 1'b1; tick(inf, o, a, e); sat_cnt_clr = 1'b0;
    send_one(64'sd8589934592, 0, 1'b1, 1'b0);
    n_tests++; if (m_data[31:0] !== 32'h7fff_ffff) begin n_fail++; $display("FAIL sat_pos: got %h exp 7fffffff", m_data[31:0]); end
    tick(inf, o, a, e);
    n_tests++; if (sat_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_cnt_1: got %0d exp 1", sat_cnt); end
    sat_en = 1'b0;
    send_one(64'sd8589934592, 0, 1'b1, 1'b0);
    n_tests++; if (m_data[31:0] !== 32'd0) begin n_fail++; $display("FAIL wrap: got %h exp 0", m_data[31:0]); end
    tick(inf, o, a, e);
    n_tests++; if (sat_cnt !== 16'd2) begin n_fail++; $display("FAIL sat_cnt_2: got %0d exp 2", sat_cnt); end
    sat_en = 1'b1;
    send_one(-64'sd2147483648, -64'sd100, 1'b0, 1'b0);
    n_tests++; if (m_data[31:0] !== 32'h8000_0000) begin n_fail++; $display("FAIL sat_neg: got %h exp 80000000", m_data[31:0]); end
    tick(inf, o, a, e);
    n_tests++; if (sat_cnt !== 16'd3) begin n_fail++; $display("FAIL sat_cnt_3: got %0d exp 3", sat_cnt); end
    send_one(64'sd8589934592, 0, 1'b1, 1'b0);
    sat_cnt_clr = 1'b1;
    tick(inf, o, a, e);
    sat_cnt_clr = 1'b0;
    n_tests++; if (o !== 1'b1 || sat_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_wins: fire %b sat_cnt %0d exp 1/0", o, sat_cnt); end
  endtask

  task automatic test_relu();
    bit inf, o; beat_t a, e;
    set_idle(); sat_en = 1'b1; relu_en = 1'b1;
    send_one(-64'sd34, 64'sd12, 1'b0, 1'b1);
    n_tests++; if (m_data[31:0] !== 32'd0 || m_last !== 1'b1)
      begin n_fail++; $display("FAIL relu_last: got %h/%b exp 0/1", m_data[31:0], m_last); end
    tick(inf, o, a, e);
    send_one(-64'sd34, 64'sd12, 1'b0, 1'b0);
    n_tests++; if (m_data[31:0] !== 32'hffff_ffea || m_last !== 1'b0)
      begin n_fail++; $display("FAIL relu_notlast: got %h/%b exp ffffffea/0", m_data[31:0], m_last); end
    tick(inf, o, a, e);
    relu_en = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [LANE_N*IN_W-1:0] fr[3];
    logic [LANE_N*32-1:0]   og[3];
    logic                   fi[3], la[3];
    logic [LANE_N*32-1:0]   snap;
    int k = 0, nout = 0;
    bit inf, o; beat_t a, e;
    set_idle(); sat_en = 1'b1; relu_en = 1'b0;
    snap = '0;
    for (int j = 0; j < 3; j++) begin
      rand_beat(); fr[j] = s_frac; og[j] = s_org_mid_res; fi[j] = s_first; la[j] = s_last;
    end
    m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      s_valid = (k < 3);
      if (k < 3) begin s_frac = fr[k]; s_org_mid_res = og[k]; s_first = fi[k]; s_last = la[k]; end
      tick(inf, o, a, e);
      if (inf) k++;
      if (c == 2) snap = m_data;
      if (c > 2) begin
        n_tests++; if (m_valid !== 1'b1 || m_data !== snap)
          begin n_fail++; $display("FAIL bp_hold: valid %b data %h exp 1/%h", m_valid, m_data, snap); end
      end
    end
    n_tests++; if (k != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d exp 2", k); end
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready: got %b exp 0", s_ready); end
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      s_valid = (k < 3);
      if (k < 3) begin s_frac = fr[k]; s_org_mid_res = og[k]; s_first = fi[k]; s_last = la[k]; end
      tick(inf, o, a, e);
      if (inf) k++;
      if (o) begin
        nout++;
        n_tests++; if (a.d !== e.d || a.l !== e.l) begin n_fail++; $display("FAIL bp_order: got %h/%b exp %h/%b", a.d, a.l, e.d, e.l); end
      end
    end
    s_valid = 1'b0;
    n_tests++; if (nout != 3) begin n_fail++; $display("FAIL bp_count: got %0d exp 3", nout); end
  endtask

  task automatic test_reset_flight();
    int nout = 0;
    bit inf, o; beat_t a, e;
    set_idle(); sat_en = 1'b1; relu_en = 1'b0;
    s_frac = '0; s_org_mid_res = '0;
    s_frac[IN_W-1:0] = 37'h2_0000_0000; s_first = 1'b1; s_valid = 1'b1;
    tick(inf, o, a, e);
    rand_beat();
    tick(inf, o, a, e);
    s_valid = 1'b0; areset = 1'b1;
    tick(inf, o, a, e);
    areset = 1'b0;
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flight_valid: got %b exp 0", m_valid); end
    n_tests++; if (sat_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_flight_cnt: got %0d exp 0", sat_cnt); end
    for (int c = 0; c < 5; c++) begin
      tick(inf, o, a, e);
      if (o) nout++;
    end
    n_tests++; if (nout != 0) begin n_fail++; $display("FAIL rst_flight_stale: got %0d beats exp 0", nout); end
  endtask

  task automatic test_aclken();
    logic [LANE_N*32-1:0] snap;
    logic snapv;
    bit inf, o; beat_t a, e;
    set_idle(); sat_en = 1'b1; relu_en = 1'b1;
    snap = '0; snapv = 1'b0;
    for (int c = 0; c < 40; c++) begin
      rand_beat();
      s_valid = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 3) != 0);
      if (c == 15) begin snap = m_data; snapv = m_valid; end
      aclken = !(c >= 15 && c < 18);
      if (!aclken) begin
        #1;
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL en_s_ready: got %b exp 0", s_ready); end
      end
      tick(inf, o, a, e);
      if (c >= 15 && c < 18) begin
        n_tests++; if (m_data !== snap || m_valid !== snapv)
          begin n_fail++; $display("FAIL en_freeze: got %h/%b exp %h/%b", m_data, m_valid, snap, snapv); end
      end
      if (o) begin n_tests++; if (a.d !== e.d || a.l !== e.l) begin n_fail++; $display("FAIL en_stream: got %h/%b exp %h/%b", a.d, a.l, e.d, e.l); end end
    end
    s_valid = 1'b0; m_ready = 1'b1; aclken = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(inf, o, a, e);
      if (o) begin n_tests++; if (a.d !== e.d || a.l !== e.l) begin n_fail++; $display("FAIL en_stream: got %h/%b exp %h/%b", a.d, a.l, e.d, e.l); end end
    end
    relu_en = 1'b0;
  endtask

  task automatic test_random();
    bit inf, o; beat_t a, e;
    set_idle();
    for (int b = 0; b < 4; b++) begin
      sat_en = b[0]; relu_en = b[1];
      for (int c = 0; c < 120; c++) begin
        rand_beat();
        s_valid = ($urandom_range(0, 3) != 0);
        m_ready = ($urandom_range(0, 3) != 0);
        aclken  = ($urandom_range(0, 9) != 0);
        tick(inf, o, a, e);
        if (o) begin n_tests++; if (a.d !== e.d || a.l !== e.l) begin n_fail++; $display("FAIL rand_stream: got %h/%b exp %h/%b", a.d, a.l, e.d, e.l); end end
      end
      s_valid = 1'b0; m_ready = 1'b1; aclken = 1'b1;
      for (int c = 0; c < 5; c++) begin
        tick(inf, o, a, e);
        if (o) begin n_tests++; if (a.d !== e.d || a.l !== e.l) begin n_fail++; $display("FAIL rand_stream: got %h/%b exp %h/%b", a.d, a.l, e.d, e.l); end end
      end
      n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_drain: %0d beats missing exp 0", q.size()); end
      n_tests++; if (sat_cnt !== 16'(exp_sat)) begin n_fail++; $display("FAIL rand_sat_cnt: got %0d exp %0d", sat_cnt, exp_sat); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_relu();
    test_backpressure();
    test_reset_flight();
    test_aclken();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
